// File: rtl/f_pcu_if.sv
// f_pcu_if: fetch PC unit bundle carrying the D-stage redirect inputs and the fetch/RAS status outputs.
interface f_pcu_if;
    logic [3:0]  D_nPCSel;
    logic [15:0] D_Imm16;
    logic [25:0] D_Imm26;
    logic [31:0] D_PC4;
    logic [31:0] D_RD1;
    logic [31:0] D_RD2;
    logic        F_Stall;
    logic        Req;
    logic        D_Eret;
    logic [31:0] EPC;
    logic [31:0] F_PC;
    logic        F_ExcAdEL;
    logic        D_RasHit;
    logic [4:0]  RasCount;
    modport master (
        output D_nPCSel, D_Imm16, D_Imm26, D_PC4, D_RD1, D_RD2, F_Stall, Req, D_Eret, EPC,
        input  F_PC, F_ExcAdEL, D_RasHit, RasCount
    );
    modport slave (
        input  D_nPCSel, D_Imm16, D_Imm26, D_PC4, D_RD1, D_RD2, F_Stall, Req, D_Eret, EPC,
        output F_PC, F_ExcAdEL, D_RasHit, RasCount
    );
endinterface

// File: rtl/f_pcu.sv
// f_pcu: fetch PC register with D-stage branch/jump redirect, exception/eret override and a return-address stack.
module f_pcu #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_PC    = 32'h0000_4180,
    parameter logic [31:0] TEXT_LO   = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI   = 32'h0000_6FFC,
    parameter int          RAS_DEPTH = 4
) (
    input logic   clk,
    input logic   reset,
    f_pcu_if.slave pif
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [3:0] SEL_BEQ = 4'd1, SEL_JAL = 4'd2, SEL_JR = 4'd3, SEL_BNE = 4'd4, SEL_BDIST = 4'd5;
    localparam logic [PW-1:0] PTR_MAX = PW'(RAS_DEPTH - 1);
    localparam logic [4:0] CNT_MAX = 5'(RAS_DEPTH);
    logic [31:0] pc, br_tgt, diff, abs_diff, tgt, next_pc;
    logic eq, taken, advance, push, pop;
    logic [PW-1:0] ptr, top;
    logic [4:0] cnt;
    logic [31:0] ras [RAS_DEPTH];
    assign eq       = pif.D_RD1 == pif.D_RD2;
    assign br_tgt   = pif.D_PC4 + {{14{pif.D_Imm16[15]}}, pif.D_Imm16, 2'b00};
    assign diff     = pif.D_RD1 - pif.D_RD2;
    assign abs_diff = diff[31] ? -diff : diff;
    assign taken    = pif.D_nPCSel == SEL_BEQ ? eq :
                      pif.D_nPCSel == SEL_BNE ? !eq :
                      (pif.D_nPCSel == SEL_JAL || pif.D_nPCSel == SEL_JR || pif.D_nPCSel == SEL_BDIST);
    assign tgt      = pif.D_nPCSel == SEL_JAL   ? {pif.D_PC4[31:28], pif.D_Imm26, 2'b00} :
                      pif.D_nPCSel == SEL_JR    ? pif.D_RD1 :
                      pif.D_nPCSel == SEL_BDIST ? br_tgt + {abs_diff[29:0], 2'b00} : br_tgt;
    assign next_pc  = pif.Req ? EXC_PC : pif.D_Eret ? pif.EPC : pif.F_Stall ? pc : taken ? tgt : pc + 32'd4;
    // The RAS only moves on cycles that actually retire the D-stage instruction.
    assign advance  = !pif.F_Stall && !pif.Req && !pif.D_Eret;
    assign push     = advance && pif.D_nPCSel == SEL_JAL;
    assign pop      = advance && pif.D_nPCSel == SEL_JR && cnt != 5'd0;
    assign top      = ptr == '0 ? PTR_MAX : ptr - 1'b1;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc  <= RESET_PC;
            ptr <= '0;
            cnt <= '0;
        end else begin
            pc <= next_pc;
            if (push) begin
                ptr <= ptr == PTR_MAX ? '0 : ptr + 1'b1;
                cnt <= cnt == CNT_MAX ? cnt : cnt + 5'd1;
            end else if (pop) begin
                ptr <= top;
                cnt <= cnt - 5'd1;
            end
        end
    end
    // Pushing into a full stack lands on the oldest slot, which is exactly the overwrite we want.
    always_ff @(posedge clk) begin
        if (reset && push) ras[ptr] <= pif.D_PC4 + 32'd4;
    end
    assign pif.F_PC      = pc;
    assign pif.F_ExcAdEL = pc[1:0] != 2'b00 || pc < TEXT_LO || pc > TEXT_HI;
    assign pif.D_RasHit  = pif.D_nPCSel == SEL_JR && cnt != 5'd0 && ras[top] == pif.D_RD1;
    assign pif.RasCount  = cnt;
endmodule

// File: tb/tb_f_pcu.sv
// tb_f_pcu: directed and randomized checks of f_pcu against a queue-based reference model.
module tb_f_pcu;
    logic clk = 1'b0;
    logic reset;
    int n_vec = 0;
    int n_err = 0;
    logic [31:0] m_pc;
    logic [31:0] ras_q[$];
    f_pcu_if pif();
    f_pcu dut (.clk(clk), .reset(reset), .pif(pif));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic idle();
        pif.D_nPCSel = 4'd0; pif.D_Imm16 = '0; pif.D_Imm26 = '0; pif.D_PC4 = '0;
        pif.D_RD1 = '0; pif.D_RD2 = '0; pif.F_Stall = 0; pif.Req = 0; pif.D_Eret = 0; pif.EPC = '0;
    endtask
    task automatic model_reset();
        m_pc = 32'h3000;
        ras_q.delete();
    endtask
    // One clock: check combinational outputs, predict, clock, then check registered state.
    task automatic tick();
        logic [31:0] br, d, ab, tgt, nxt;
        bit tk, adv, hit;
        int sd;
        #1;
        hit = pif.D_nPCSel == 4'd3 && ras_q.size() > 0 && ras_q[$] == pif.D_RD1;
        check("ras_hit", 32'(pif.D_RasHit), 32'(hit));
        check("exc_adel", 32'(pif.F_ExcAdEL), 32'(m_pc[1:0] != 0 || m_pc < 32'h3000 || m_pc > 32'h6FFC));
        br = pif.D_PC4 + 32'($signed(pif.D_Imm16)) * 4;
        d  = pif.D_RD1 - pif.D_RD2;
        sd = d;
        ab = sd < 0 ? 32'(-sd) : d;
        tk = 0; tgt = '0;
        case (pif.D_nPCSel)
            4'd1: begin tk = pif.D_RD1 == pif.D_RD2; tgt = br; end
            4'd2: begin tk = 1; tgt = {pif.D_PC4[31:28], pif.D_Imm26, 2'b00}; end
            4'd3: begin tk = 1; tgt = pif.D_RD1; end
            4'd4: begin tk = pif.D_RD1 != pif.D_RD2; tgt = br; end
            4'd5: begin tk = 1; tgt = br + ab * 4; end
            default: ;
        endcase
        nxt = pif.Req ? 32'h4180 : pif.D_Eret ? pif.EPC : pif.F_Stall ? m_pc : tk ? tgt : m_pc + 4;
        adv = !pif.F_Stall && !pif.Req && !pif.D_Eret;
        if (adv && pif.D_nPCSel == 4'd2) begin
            ras_q.push_back(pif.D_PC4 + 4);
            if (ras_q.size() > 4) void'(ras_q.pop_front());
        end else if (adv && pif.D_nPCSel == 4'd3 && ras_q.size() > 0) void'(ras_q.pop_back());
        @(posedge clk);
        #1;
        m_pc = nxt;
        check("f_pc", pif.F_PC, m_pc);
        check("ras_count", 32'(pif.RasCount), 32'(ras_q.size()));
    endtask
    task automatic jx(input logic [3:0] sel, input logic [31:0] pc4, input logic [31:0] rd1);
        idle();
        pif.D_nPCSel = sel; pif.D_PC4 = pc4; pif.D_RD1 = rd1;
    endtask
    initial begin
        idle();
        reset = 0;
        model_reset();
        #12;
        check("rst_pc", pif.F_PC, 32'h3000);
        check("rst_count", 32'(pif.RasCount), 32'd0);
        check("rst_adel", 32'(pif.F_ExcAdEL), 32'd0);
        check("rst_hit", 32'(pif.D_RasHit), 32'd0);
        @(negedge clk);
        reset = 1;
        tick(); check("seq1", pif.F_PC, 32'h3004);
        tick(); check("seq2", pif.F_PC, 32'h3008);
        pif.F_Stall = 1;
        tick(); check("stall1", pif.F_PC, 32'h3008);
        tick(); check("stall2", pif.F_PC, 32'h3008);
        idle();
        pif.D_nPCSel = 4'd1; pif.D_PC4 = 32'h3010; pif.D_Imm16 = 16'hFFFF; pif.D_RD1 = 5; pif.D_RD2 = 5;
        tick(); check("beq_taken", pif.F_PC, 32'h300C);
        idle(); tick(); check("add4", pif.F_PC, 32'h3010);
        pif.D_nPCSel = 4'd1; pif.D_PC4 = 32'h3010; pif.D_Imm16 = 16'hFFFF; pif.D_RD1 = 5; pif.D_RD2 = 6;
        tick(); check("beq_not", pif.F_PC, 32'h3014);
        pif.D_nPCSel = 4'd4;
        tick(); check("bne_taken", pif.F_PC, 32'h300C);
        idle();
        pif.D_nPCSel = 4'd5; pif.D_PC4 = 32'h3000; pif.D_Imm16 = 16'd1; pif.D_RD1 = 2; pif.D_RD2 = 7;
        tick(); check("bdist", pif.F_PC, 32'h3018);
        idle();
        pif.Req = 1; pif.F_Stall = 1; pif.D_Eret = 1; pif.EPC = 32'h3040;
        tick(); check("req_prio", pif.F_PC, 32'h4180);
        pif.Req = 0;
        tick(); check("eret_stall", pif.F_PC, 32'h3040);
        for (int i = 0; i < 5; i++) begin
            jx(4'd2, 32'h3004 + 32'(i) * 32'h100, 0);
            pif.D_Imm26 = 26'h0C00;
            tick();
        end
        check("ras_full", 32'(pif.RasCount), 32'd4);
        for (int i = 0; i < 4; i++) begin
            jx(4'd3, 0, 32'h3408 - 32'(i) * 32'h100);
            #1;
            check("ras_pop_hit", 32'(pif.D_RasHit), 32'd1);
            tick();
        end
        check("ras_empty", 32'(pif.RasCount), 32'd0);
        jx(4'd3, 0, 32'h3008);
        #1;
        check("ras_lost", 32'(pif.D_RasHit), 32'd0);
        tick();
        check("ras_stay0", 32'(pif.RasCount), 32'd0);
        jx(4'd3, 0, 32'h3002); tick();
        check("adel_mis", 32'(pif.F_ExcAdEL), 32'd1);
        jx(4'd3, 0, 32'h7000); tick();
        check("adel_hi", 32'(pif.F_ExcAdEL), 32'd1);
        jx(4'd2, 32'h3100, 0); tick();
        idle(); pif.F_Stall = 1; pif.Req = 1;
        @(posedge clk);
        #2;
        reset = 0;
        #1;
        check("async_pc", pif.F_PC, 32'h3000);
        check("async_cnt", 32'(pif.RasCount), 32'd0);
        model_reset();
        @(negedge clk);
        idle();
        reset = 1;
        for (int i = 0; i < 400; i++) begin
            pif.D_nPCSel = 4'($urandom_range(0, 15) < 10 ? $urandom_range(0, 5) : $urandom_range(6, 15));
            pif.D_Imm16 = 16'($urandom);
            pif.D_Imm26 = 26'($urandom);
            pif.D_PC4 = 32'h3000 + (32'($urandom_range(0, 4095)) << 2);
            pif.D_RD1 = $urandom_range(0, 3) == 0 ? 32'h8000_0000 : 32'($urandom);
            pif.D_RD2 = $urandom_range(0, 2) == 0 ? pif.D_RD1 : 32'($urandom_range(0, 3)) == 0 ? 32'd0 : 32'($urandom);
            if (pif.D_nPCSel == 4'd3 && ras_q.size() > 0 && $urandom_range(0, 1) == 1) pif.D_RD1 = ras_q[$];
            pif.F_Stall = $urandom_range(0, 4) == 0;
            pif.Req = $urandom_range(0, 19) == 0;
            pif.D_Eret = $urandom_range(0, 19) == 0;
            pif.EPC = 32'($urandom);
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/f_pcu.md
F_PCU -- requirements
Module: F_PCU

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000: PC value loaded on reset.
REQ-002 Parameter EXC_PC, default 32'h0000_4180: exception handler entry address.
REQ-003 Parameter TEXT_LO, default 32'h0000_3000: lowest legal fetch address.
REQ-004 Parameter TEXT_HI, default 32'h0000_6FFC: highest legal fetch address.
REQ-005 Parameter RAS_DEPTH, default 4, legal range 2..16: return-address-stack entries.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 D_nPCSel  input  4  D-stage next-PC code: 0 ADD4, 1 BEQ, 2 JAL, 3 JR, 4 BNE, 5 BDIST; codes 6..15 behave as ADD4.
REQ-009 D_Imm16  input  16  branch offset.
REQ-010 D_Imm26  input  26  jump index.
REQ-011 D_PC4  input  32  D-stage PC+4.
REQ-012 D_RD1, D_RD2  input  32 each  forwarded register operands.
REQ-013 F_Stall  input  1  hold the PC.
REQ-014 Req  input  1  exception/interrupt redirect.
REQ-015 D_Eret  input  1  eret in D.
REQ-016 EPC  input  32  eret return address.
REQ-017 F_PC  output  32  current fetch PC (registered).
REQ-018 F_ExcAdEL  output  1  current PC is misaligned or outside [TEXT_LO, TEXT_HI].
REQ-019 D_RasHit  output  1  JR in D matches the predicted return address.
REQ-020 RasCount  output  5  number of valid RAS entries.

Function
REQ-021 The block SHALL compute eq = (D_RD1 == D_RD2) internally; no external zero flag.
REQ-022 Branch target SHALL be D_PC4 + (sext(D_Imm16) << 2), computed modulo 2^32.
REQ-023 JAL target SHALL be {D_PC4[31:28], D_Imm26, 2'b00}.
REQ-024 JR target SHALL be D_RD1, unmodified.
REQ-025 BDIST target SHALL be the branch target + (|D_RD1 - D_RD2| << 2), computed modulo 2^32.
REQ-026 In BDIST, |x| SHALL be the 32-bit two's-complement absolute value of the 32-bit difference; |0x8000_0000| = 0x8000_0000.
REQ-027 BEQ SHALL redirect only when eq = 1, and BNE only when eq = 0.
REQ-028 JAL, JR and BDIST SHALL always redirect.
REQ-029 Next-PC priority, highest first:
  - Req -> EXC_PC
  - D_Eret -> EPC
  - F_Stall -> hold F_PC
  - taken D redirect -> its target
  - otherwise F_PC + 4
REQ-030 Req and D_Eret SHALL override F_Stall.
REQ-031 F_PC SHALL update on every rising edge; redirect latency is 1 cycle.
REQ-032 F_ExcAdEL SHALL be combinational from F_PC: set when F_PC[1:0] != 0, F_PC < TEXT_LO, or F_PC > TEXT_HI.
REQ-033 The RAS SHALL be a circular LIFO of RAS_DEPTH 32-bit entries, with a top pointer and a saturating count.
REQ-034 A RAS push SHALL occur when D_nPCSel = JAL and the cycle advances (F_Stall = 0, Req = 0, D_Eret = 0); pushed value = D_PC4 + 4.
REQ-035 A RAS pop SHALL occur when D_nPCSel = JR, the cycle advances, and count > 0.
REQ-036 Push when full SHALL overwrite the oldest entry, with count staying at RAS_DEPTH.
REQ-037 Pop when count = 0 SHALL change no state.
REQ-038 D_RasHit SHALL be combinational: 1 iff D_nPCSel = JR, count > 0 and top entry == D_RD1; otherwise 0.
REQ-039 D_RasHit SHALL be informational only; the JR target is always D_RD1.
REQ-040 Req SHALL leave the RAS contents and count unchanged.

Reset
REQ-041 While reset = 0, F_PC SHALL be RESET_PC, RasCount SHALL be 0 and the RAS pointer SHALL be 0, asynchronously and independent of clk.
REQ-042 At reset with default parameters, F_ExcAdEL = 0 and D_RasHit = 0.
REQ-043 Reset asserted mid-operation (including mid-stall or with Req high) SHALL take effect immediately.
REQ-044 After reset release, the first rising edge SHALL apply normal next-PC selection.

Verification
REQ-045 Reset, then no redirects: F_PC sequence 0x3000, 0x3004, 0x3008; asserting F_Stall for 2 cycles holds 0x3008 twice.
REQ-046 Branches with D_PC4 = 0x3010:
  - BEQ, Imm16 = 0xFFFF, RD1 = RD2 = 5 -> next F_PC 0x300C
  - same with RD2 = 6 -> 0x3014 when F_PC = 0x3010
  - BNE, RD1 = 5, RD2 = 6 -> 0x300C
REQ-047 BDIST, D_PC4 = 0x3000, Imm16 = 1, RD1 = 2, RD2 = 7 -> F_PC 0x3018.
REQ-048 Req = 1 together with F_Stall = 1 and D_Eret = 1 -> F_PC 0x4180; D_Eret alone with EPC = 0x3040 and F_Stall = 1 -> 0x3040.
REQ-049 RAS with RAS_DEPTH = 4:
  - 5 JALs with D_PC4 = 0x3004, 0x3104, 0x3204, 0x3304, 0x3404 -> RasCount 4
  - JR with RD1 = 0x3408 -> D_RasHit = 1; after the pop, JR with RD1 = 0x3308 -> D_RasHit = 1
  - 4 pops in total -> count 0; 0x3008 was lost to overwrite
  - a further JR -> D_RasHit = 0, count stays 0
REQ-050 F_PC = 0x3002 -> F_ExcAdEL = 1; F_PC = 0x7000 -> F_ExcAdEL = 1; reset asserted mid-stall -> F_PC = 0x3000 before the next clock edge.
